// File: rtl/cond_exec_sequencer.sv
// cond_exec_sequencer: conditional-execution sequencer in front of the ALU issue port.
// Holds the architectural NZCV flags and counts in-flight flag-setting ops. Each accepted
// instruction's ARM condition code is evaluated once the flags are stable. The instruction
// is then issued to the ALU or squashed with a one-cycle pulse.
// Optional feature macro: COND_EXEC_PERF_CNT_EN enables the 16-bit executed/squashed
// counters. When the macro is undefined, both counter outputs are tied to zero.
module cond_exec_sequencer #(
  parameter int          TAG_W       = 8,
  parameter int          MAX_PENDING = 3,
  parameter logic [3:0]  FLAG_RESET  = 4'h0,
  localparam int         PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [3:0]        instr_cond_i,
  input  logic              instr_sets_flags_i,
  input  logic [TAG_W-1:0]  instr_tag_i,
  output logic              exec_valid_o,
  input  logic              exec_ready_i,
  output logic              exec_sets_flags_o,
  output logic [TAG_W-1:0]  exec_tag_o,
  output logic              squash_o,
  output logic [TAG_W-1:0]  squash_tag_o,
  input  logic              flag_wr_en_i,
  input  logic [3:0]        flag_wr_data_i,
  output logic [3:0]        flags_o,
  output logic [PEND_W-1:0] pending_o,
  output logic [15:0]       exec_cnt_o,
  output logic [15:0]       squash_cnt_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_ISSUE  = 2'd2,
    S_SQUASH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                instr_ready_q;
  logic                exec_valid_q;
  logic                exec_sets_q;
  logic [TAG_W-1:0]    exec_tag_q;
  logic                squash_q;
  logic [TAG_W-1:0]    squash_tag_q;
  logic [3:0]          flags_q;
  logic [PEND_W-1:0]   pending_q;
  logic [3:0]          cond_q;
  logic                sets_q;
  logic [TAG_W-1:0]    tag_q;
  logic                pend_inc;
  logic                pend_dec;

  // ARM condition table. Flags are ordered {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    r  = 1'b0;
    case (c)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = cy;
      4'h3: r = !cy;
      4'h4: r = n;
      4'h5: r = !n;
      4'h6: r = v;
      4'h7: r = !v;
      4'h8: r = cy && !z;
      4'h9: r = !cy || z;
      4'hA: r = (n == v);
      4'hB: r = (n != v);
      4'hC: r = !z && (n == v);
      4'hD: r = z || (n != v);
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state logic. AL and NV resolve immediately. Other conditions wait until no
  // flag-setter is in flight. A flag-setter also waits while the pending counter is full.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid_i && instr_ready_q) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (cond_q == 4'hF)                              state_d = S_SQUASH;
        else if (cond_q != 4'hE && pending_q != '0)      state_d = S_EVAL;
        else if (!cond_pass(cond_q, flags_q))            state_d = S_SQUASH;
        else if (sets_q && pending_q == PEND_MAX)        state_d = S_EVAL;
        else                                             state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (exec_ready_i) state_d = S_IDLE;
      end
      S_SQUASH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register and registered handshake/issue outputs. Tags are loaded on entry to ISSUE/SQUASH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      instr_ready_q <= 1'b1;
      exec_valid_q  <= 1'b0;
      exec_sets_q   <= 1'b0;
      exec_tag_q    <= '0;
      squash_q      <= 1'b0;
      squash_tag_q  <= '0;
    end else begin
      state_q       <= state_d;
      instr_ready_q <= (state_d == S_IDLE);
      exec_valid_q  <= (state_d == S_ISSUE);
      squash_q      <= (state_d == S_SQUASH);
      if (state_q == S_EVAL && state_d == S_ISSUE) begin
        exec_tag_q  <= tag_q;
        exec_sets_q <= sets_q;
      end
      if (state_q == S_EVAL && state_d == S_SQUASH) begin
        squash_tag_q <= tag_q;
      end
    end
  end

  // Capture the accepted instruction. This is data only; IDLE never consumes it.
  always_ff @(posedge clk_i) begin
    if (instr_valid_i && instr_ready_q) begin
      cond_q <= instr_cond_i;
      sets_q <= instr_sets_flags_i;
      tag_q  <= instr_tag_i;
    end
  end

  assign pend_inc = exec_valid_q && exec_ready_i && exec_sets_q;
  assign pend_dec = flag_wr_en_i;

  // Architectural flags and in-flight flag-setter count. The count saturates at both ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q   <= FLAG_RESET;
      pending_q <= '0;
    end else begin
      if (flag_wr_en_i) flags_q <= flag_wr_data_i;
      case ({pend_inc, pend_dec})
        2'b10:   if (pending_q != PEND_MAX) pending_q <= pending_q + PEND_W'(1);
        2'b01:   if (pending_q != '0)       pending_q <= pending_q - PEND_W'(1);
        default: pending_q <= pending_q;
      endcase
    end
  end

`ifdef COND_EXEC_PERF_CNT_EN
  logic [15:0] exec_cnt_q;
  logic [15:0] squash_cnt_q;

  // Wrapping performance counters. Only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exec_cnt_q   <= 16'h0000;
      squash_cnt_q <= 16'h0000;
    end else begin
      if (exec_valid_q && exec_ready_i) exec_cnt_q   <= exec_cnt_q + 16'd1;
      if (squash_q)                     squash_cnt_q <= squash_cnt_q + 16'd1;
    end
  end

  assign exec_cnt_o   = exec_cnt_q;
  assign squash_cnt_o = squash_cnt_q;
`else
  assign exec_cnt_o   = 16'h0000;
  assign squash_cnt_o = 16'h0000;
`endif

  assign instr_ready_o     = instr_ready_q;
  assign exec_valid_o      = exec_valid_q;
  assign exec_sets_flags_o = exec_sets_q;
  assign exec_tag_o        = exec_tag_q;
  assign squash_o          = squash_q;
  assign squash_tag_o      = squash_tag_q;
  assign flags_o           = flags_q;
  assign pending_o         = pending_q;

endmodule

// File: tb/tb_cond_exec_sequencer.sv
// Directed bench for cond_exec_sequencer with a scoreboard of expected issue/squash outcomes.
module tb_cond_exec_sequencer;

  localparam int KIND_NONE = 0;
  localparam int KIND_EXEC = 1;
  localparam int KIND_SQ   = 2;

`ifdef COND_EXEC_PERF_CNT_EN
  localparam logic [15:0] EXP_EC = 16'd2;
  localparam logic [15:0] EXP_SC = 16'd1;
`else
  localparam logic [15:0] EXP_EC = 16'd0;
  localparam logic [15:0] EXP_SC = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_cond;
  logic        instr_sets;
  logic [7:0]  instr_tag;
  logic        exec_valid;
  logic        exec_ready;
  logic        exec_sets;
  logic [7:0]  exec_tag;
  logic        squash;
  logic [7:0]  squash_tag;
  logic        flag_wr_en;
  logic [3:0]  flag_wr_data;
  logic [3:0]  flags;
  logic [1:0]  pending;
  logic [15:0] exec_cnt;
  logic [15:0] squash_cnt;

  typedef struct packed {
    logic       is_exec;
    logic       sets;
    logic [7:0] tag;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [3:0] flags_m;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  cond_exec_sequencer #(.TAG_W(8), .MAX_PENDING(3), .FLAG_RESET(4'h0)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .instr_valid_i     (instr_valid),
    .instr_ready_o     (instr_ready),
    .instr_cond_i      (instr_cond),
    .instr_sets_flags_i(instr_sets),
    .instr_tag_i       (instr_tag),
    .exec_valid_o      (exec_valid),
    .exec_ready_i      (exec_ready),
    .exec_sets_flags_o (exec_sets),
    .exec_tag_o        (exec_tag),
    .squash_o          (squash),
    .squash_tag_o      (squash_tag),
    .flag_wr_en_i      (flag_wr_en),
    .flag_wr_data_i    (flag_wr_data),
    .flags_o           (flags),
    .pending_o         (pending),
    .exec_cnt_o        (exec_cnt),
    .squash_cnt_o      (squash_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference condition evaluation. Flags are ordered {N,Z,C,V}.
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return cy;
      4'h3: return ~cy;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return cy & ~z;
      4'h9: return ~cy | z;
      4'hA: return ~(n ^ v);
      4'hB: return n ^ v;
      4'hC: return ~z & ~(n ^ v);
      4'hD: return z | (n ^ v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compare every issue handshake and squash pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && ((exec_valid && exec_ready) || squash)) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("out_kind", 32'(exec_valid), 32'(mon_e.is_exec));
        check("out_tag", 32'(exec_valid ? exec_tag : squash_tag), 32'(mon_e.tag));
        if (exec_valid) check("out_sets", 32'(exec_sets), 32'(mon_e.sets));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !instr_ready; i++) tick();
    check("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  task automatic send(input logic [3:0] c, input logic s, input logic [7:0] t, input int kind);
    exp_t e;
    wait_ready();
    instr_valid = 1'b1;
    instr_cond  = c;
    instr_sets  = s;
    instr_tag   = t;
    if (kind != KIND_NONE) begin
      e.is_exec = (kind == KIND_EXEC);
      e.sets    = s;
      e.tag     = t;
      sb_q.push_back(e);
    end
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic flag_write(input logic [3:0] d);
    flag_wr_en   = 1'b1;
    flag_wr_data = d;
    flags_m      = d;
    tick();
    flag_wr_en   = 1'b0;
  endtask

  initial begin
    logic [3:0] fv [6];
    fv = '{4'b0000, 4'b0100, 4'b1001, 4'b0010, 4'b1000, 4'b0110};
    rst = 1'b1; instr_valid = 1'b0; instr_cond = 4'h0; instr_sets = 1'b0; instr_tag = 8'h00;
    exec_ready = 1'b1; flag_wr_en = 1'b0; flag_wr_data = 4'h0; flags_m = 4'h0;
    tick(); tick();
    check("rst_ready",   32'(instr_ready), 32'd1);
    check("rst_valid",   32'(exec_valid),  32'd0);
    check("rst_squash",  32'(squash),      32'd0);
    check("rst_flags",   32'(flags),       32'd0);
    check("rst_pending", 32'(pending),     32'd0);
    check("rst_etag",    32'(exec_tag),    32'd0);
    check("rst_stag",    32'(squash_tag),  32'd0);
    check("rst_ecnt",    32'(exec_cnt),    32'd0);
    check("rst_scnt",    32'(squash_cnt),  32'd0);
    rst = 1'b0;
    tick();

    // AL issue timing: accepted at T, EXEC_VALID at T+2
    send(4'hE, 1'b0, 8'h11, KIND_EXEC);
    check("al_eval_valid", 32'(exec_valid),  32'd0);
    check("al_eval_ready", 32'(instr_ready), 32'd0);
    tick();
    check("al_valid", 32'(exec_valid), 32'd1);
    check("al_tag",   32'(exec_tag),   32'h11);
    check("al_flags", 32'(flags),      32'd0);
    tick();
    check("al_idle",  32'(instr_ready), 32'd1);

    // flag write at PENDING=0; EQ pass and NE squash
    flag_write(4'b0100);
    check("nounder_pending", 32'(pending), 32'd0);
    check("nounder_flags",   32'(flags),   32'b0100);
    send(4'h0, 1'b0, 8'h22, KIND_EXEC);
    tick();
    check("eq_issue", 32'(exec_valid), 32'd1);
    tick();
    send(4'h1, 1'b0, 8'h33, KIND_SQ);
    tick();
    check("ne_squash", 32'(squash),     32'd1);
    check("ne_stag",   32'(squash_tag), 32'h33);
    check("ne_novld",  32'(exec_valid), 32'd0);
    tick();
    check("ne_pulse",  32'(squash),      32'd0);
    check("ne_idle",   32'(instr_ready), 32'd1);

    // GE held while a flag-setter is in flight
    send(4'hE, 1'b1, 8'h44, KIND_EXEC);
    tick(); tick();
    check("fs_pending", 32'(pending), 32'd1);
    send(4'hA, 1'b0, 8'h55, KIND_EXEC);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ge_hold", 32'(exec_valid), 32'd0);
    end
    flag_write(4'b1001);
    check("ge_pending", 32'(pending),    32'd0);
    check("ge_flags",   32'(flags),      32'b1001);
    check("ge_still",   32'(exec_valid), 32'd0);
    tick();
    check("ge_issue",   32'(exec_valid), 32'd1);
    tick();

    // EXEC_READY backpressure
    exec_ready = 1'b0;
    send(4'hE, 1'b0, 8'h66, KIND_EXEC);
    tick();
    check("bp_valid0", 32'(exec_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(exec_valid),  32'd1);
      check("bp_tag",   32'(exec_tag),    32'h66);
      check("bp_ready", 32'(instr_ready), 32'd0);
    end
    exec_ready = 1'b1;
    tick();
    check("bp_idle",   32'(instr_ready), 32'd1);
    check("bp_done",   32'(exec_valid),  32'd0);

    // simultaneous increment and decrement
    send(4'hE, 1'b1, 8'h77, KIND_EXEC);
    tick(); tick();
    check("sim_pre", 32'(pending), 32'd1);
    send(4'hE, 1'b1, 8'h88, KIND_EXEC);
    tick();
    flag_write(4'b0010);
    check("sim_pending", 32'(pending), 32'd1);
    check("sim_flags",   32'(flags),   32'b0010);
    flag_write(4'b0010);
    check("sim_clear",   32'(pending), 32'd0);

    // flag-setter blocked while PENDING==MAX_PENDING
    for (int i = 0; i < 3; i++) begin
      send(4'hE, 1'b1, 8'hA1 + 8'(i), KIND_EXEC);
      tick(); tick();
    end
    check("max_full", 32'(pending), 32'd3);
    send(4'hE, 1'b1, 8'hA4, KIND_EXEC);
    tick();
    check("max_hold0", 32'(exec_valid), 32'd0);
    tick();
    check("max_hold1", 32'(exec_valid), 32'd0);
    flag_write(4'b0010);
    check("max_dec",   32'(pending),    32'd2);
    check("max_hold2", 32'(exec_valid), 32'd0);
    tick();
    check("max_issue", 32'(exec_valid), 32'd1);
    tick();
    check("max_refill", 32'(pending), 32'd3);
    for (int i = 0; i < 3; i++) flag_write(4'b0010);
    check("max_drain", 32'(pending), 32'd0);

    // NV always squashes
    send(4'hF, 1'b0, 8'h99, KIND_SQ);
    tick();
    check("nv_squash", 32'(squash),     32'd1);
    check("nv_stag",   32'(squash_tag), 32'h99);
    tick();

    // every condition code under several flag patterns
    for (int f = 0; f < 6; f++) begin
      flag_write(fv[f]);
      for (int c = 0; c < 16; c++) begin
        send(4'(c), 1'b0, {4'(f), 4'(c)},
             model_pass(4'(c), flags_m) ? KIND_EXEC : KIND_SQ);
        tick(); tick();
      end
    end

    // reset while waiting in EVAL
    flag_write(4'hF);
    send(4'hE, 1'b1, 8'hB0, KIND_EXEC);
    tick(); tick();
    check("evrst_pre", 32'(pending), 32'd1);
    send(4'h0, 1'b0, 8'hB1, KIND_NONE);
    tick();
    rst = 1'b1;
    #1;
    check("evrst_ready",   32'(instr_ready), 32'd1);
    check("evrst_valid",   32'(exec_valid),  32'd0);
    check("evrst_pending", 32'(pending),     32'd0);
    check("evrst_flags",   32'(flags),       32'd0);
    check("evrst_etag",    32'(exec_tag),    32'd0);
    check("evrst_stag",    32'(squash_tag),  32'd0);
    tick();
    rst = 1'b0;
    tick();

    // reset while holding in ISSUE
    exec_ready = 1'b0;
    send(4'hE, 1'b0, 8'hC1, KIND_NONE);
    tick();
    check("isrst_pre", 32'(exec_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("isrst_valid", 32'(exec_valid),  32'd0);
    check("isrst_etag",  32'(exec_tag),    32'd0);
    check("isrst_ready", 32'(instr_ready), 32'd1);
    check("isrst_ecnt",  32'(exec_cnt),    32'd0);
    tick();
    rst = 1'b0;
    exec_ready = 1'b1;
    tick();

    // performance counters: two issues and one NV squash
    send(4'hE, 1'b0, 8'hD1, KIND_EXEC);
    tick(); tick();
    send(4'hE, 1'b0, 8'hD2, KIND_EXEC);
    tick(); tick();
    send(4'hF, 1'b0, 8'hD3, KIND_SQ);
    tick(); tick();
    check("perf_exec",   32'(exec_cnt),   32'(EXP_EC));
    check("perf_squash", 32'(squash_cnt), 32'(EXP_SC));

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
